// File: rtl/right_shifter_pipe_if.sv
// Operand/result handshake bundle for the pipelined right shifter.
// Producer drives in_valid/x/sc/md and out_ready; the shifter drives in_ready/out_valid/y.
interface right_shifter_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [4:0]  sc;
  logic        md;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  modport master (
    output in_valid, x, sc, md, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, sc, md, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/right_shifter_pipe.sv
// Three-stage 32-bit right shifter (ASR / ROR), one shift-count mux level per stage.
// Valid/ready: a transfer happens on any edge where valid & ready are both high; payload is held until then.
module right_shifter_pipe (
  input  logic                  clk,
  input  logic                  rst,
  right_shifter_pipe_if.slave   bus
);

  logic        v1, v2, v3;
  logic [31:0] d1, d2, d3;
  logic [2:0]  sc1;
  logic        md1;
  logic        sc2;
  logic        md2;
  logic        adv1, adv2, adv3;
  logic        accept;

  // Shift right by n; ASR fills from a[31], which every ASR stage preserves.
  function automatic logic [31:0] shr(input logic [31:0] a, input logic [4:0] n, input logic rot);
    logic [5:0] back;
    back = 6'd32 - {1'b0, n};
    if (rot)
      shr = (a >> n) | (a << back);
    else
      shr = $unsigned($signed(a) >>> n);
  endfunction

  always_comb begin
    adv3   = bus.out_ready | ~v3;
    adv2   = adv3 | ~v2;
    adv1   = adv2 | ~v1;
    accept = adv1 & ~rst;
  end

  assign bus.in_ready  = accept;
  assign bus.out_valid = v3;
  assign bus.y         = d3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      d1  <= '0;
      d2  <= '0;
      d3  <= '0;
      sc1 <= '0;
      md1 <= 1'b0;
      sc2 <= 1'b0;
      md2 <= 1'b0;
    end else begin
      if (adv1) begin
        v1  <= bus.in_valid & accept;
        d1  <= shr(bus.x, {3'b000, bus.sc[1:0]}, bus.md);
        sc1 <= bus.sc[4:2];
        md1 <= bus.md;
      end
      if (adv2) begin
        v2  <= v1;
        d2  <= shr(d1, {1'b0, sc1[1:0], 2'b00}, md1);
        sc2 <= sc1[2];
        md2 <= md1;
      end
      if (adv3) begin
        v3  <= v2;
        d3  <= shr(d2, {sc2, 4'b0000}, md2);
      end
    end
  end

endmodule

// File: tb/tb_right_shifter_pipe.sv
// Bench for right_shifter_pipe: vector table with latency checks, back-to-back,
// back-pressure, full-pipe pass-through and mid-flight reset sequences.
module tb_right_shifter_pipe;

  logic clk;
  logic rst;
  right_shifter_pipe_if bus ();

  right_shifter_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int acc_cnt  = 0;
  int out_cnt  = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] out_y_q[$];
  int          out_cyc_q[$];

  typedef struct {
    logic [31:0] x;
    logic [4:0]  sc;
    logic        md;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
  endtask

  // bit-serial reference model
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] n, input logic rot);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < 32; i++)
      if (i < int'(n)) r = rot ? {r[0], r[31:1]} : {r[31], r[31:1]};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: push on input transfer, pop/compare on output transfer
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_shift(bus.x, bus.sc, bus.md));
        acc_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        out_y_q.push_back(bus.y);
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_output", bus.y, 32'hxxxx_xxxx);
        else check("scoreboard_y", bus.y, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called at posedge+#1)
  task automatic send(input logic [31:0] xv, input logic [4:0] scv, input logic mdv);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.x  = xv;
    bus.sc = scv;
    bus.md = mdv;
    @(negedge clk);
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_timed(input logic [31:0] xv, input logic [4:0] scv, input logic mdv,
                            input logic [31:0] expv);
    int c;
    send(xv, scv, mdv);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.out_valid && c < 10);
    check("latency", 32'(c), 32'd3);
    check("y_direct", bus.y, expv);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    int base_acc, base_out, n;
    vecs[0] = '{32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFF};
    vecs[1] = '{32'h7FFF_FFF0, 5'd4,  1'b0, 32'h07FF_FFFF};
    vecs[2] = '{32'h0000_0001, 5'd1,  1'b1, 32'h8000_0000};
    vecs[3] = '{32'h1234_5678, 5'd16, 1'b1, 32'h5678_1234};
    vecs[4] = '{32'h0000_0001, 5'd31, 1'b1, 32'h0000_0002};
    vecs[5] = '{32'h9ABC_DEF0, 5'd0,  1'b0, 32'h9ABC_DEF0};
    vecs[6] = '{32'h9ABC_DEF0, 5'd0,  1'b1, 32'h9ABC_DEF0};
    vecs[7] = '{32'hF000_0000, 5'd4,  1'b0, 32'hFF00_0000};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.sc        = '0;
    bus.md        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_y", bus.y, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // table-driven vectors
    foreach (vecs[i]) send_timed(vecs[i].x, vecs[i].sc, vecs[i].md, vecs[i].exp);
    drain();

    // four back-to-back operations
    out_y_q.delete();
    out_cyc_q.delete();
    send(32'hF000_0000, 5'd4, 1'b0);
    send(32'h0000_000F, 5'd4, 1'b1);
    send(32'h0000_0100, 5'd8, 1'b0);
    send(32'hAAAA_AAAA, 5'd1, 1'b1);
    drain();
    check("b2b_count", 32'(out_y_q.size()), 32'd4);
    if (out_y_q.size() == 4) begin
      check("b2b_y0", out_y_q[0], 32'hFF00_0000);
      check("b2b_y1", out_y_q[1], 32'hF000_0000);
      check("b2b_y2", out_y_q[2], 32'h0000_0001);
      check("b2b_y3", out_y_q[3], 32'h5555_5555);
      for (int i = 0; i < 3; i++)
        check("b2b_consecutive", 32'(out_cyc_q[i+1] - out_cyc_q[i]), 32'd1);
    end

    // back-pressure: 5 offered, only 3 fit
    bus.out_ready = 1'b0;
    base_acc = acc_cnt;
    base_out = out_cnt;
    fork
      for (int i = 0; i < 5; i++)
        send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    join_none
    repeat (6) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_accepted", 32'(acc_cnt - base_acc), 32'd3);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_y_hold", bus.y, exp_q[0]);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    n = 0;
    while (out_cnt - base_out < 5 && n < 60) begin
      @(negedge clk);
      n++;
    end
    wait fork;
    check("bp_total_out", 32'(out_cnt - base_out), 32'd5);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // full pipe: simultaneous output and input transfer
    bus.out_ready = 1'b0;
    send(32'h8765_4321, 5'd3, 1'b0);
    send(32'h8765_4321, 5'd7, 1'b1);
    send(32'h0F0F_0F0F, 5'd20, 1'b1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x  = 32'hC000_0003;
    bus.sc = 5'd2;
    bus.md = 1'b1;
    @(negedge clk);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("full_stays_full", {31'd0, bus.in_ready}, 32'd0);
    check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("full_queue_depth", 32'(exp_q.size()), 32'd3);
    @(posedge clk);
    #1;
    drain();

    // reset with three operations in flight
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 5'd5, 1'b0);
    send(32'hCAFE_F00D, 5'd9, 1'b1);
    send(32'h1357_9BDF, 5'd17, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_y", bus.y, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    base_out = out_cnt;
    @(negedge clk);
    check("rst_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_timed(32'h8000_0001, 5'd1, 1'b0, 32'hC000_0000);
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_stale", 32'(out_cnt - base_out), 32'd1);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
